// File: rtl/nano_mem_responder.sv
// Memory-side responder for the NanoCPU: owns the 256x16 RAM, loads a program image
// while holding the CPU in reset, and diverts I/O-window writes into an output FIFO.
module nano_mem_responder #(
    parameter logic [7:0] IO_BASE    = 8'hF0,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic        ck,
    input  logic        rst_n,
    input  logic [7:0]  address,
    output logic [15:0] dataR,
    input  logic [15:0] dataW,
    input  logic        ce,
    input  logic        we,
    output logic        cpu_rst,
    input  logic        reload,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [15:0] ld_data,
    input  logic        ld_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_addr,
    output logic [15:0] out_data,
    output logic        ovf
);
    // state | meaning
    // LOAD  | CPU held in reset; host streams image into RAM at ptr
    // RUN   | CPU owns the bus; I/O-window writes go to the output FIFO
    typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FIFO_ONE = {{AW{1'b0}}, 1'b1};

    state_t      state, state_nxt;
    logic [7:0]  ptr;
    logic [15:0] ram [0:255];
    logic [19:0] fifo_mem [0:(1<<AW)-1];
    logic [19:0] fifo_head;
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_full, fifo_empty, in_io;
    logic        ld_fire, cpu_wr, ram_we, push_req, push, pop, drop, flush;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cpu_rst   = 1'b1;
        ld_ready  = 1'b1;
        case (state)
            LOAD: begin
                if (!reload && ld_valid && ld_last) state_nxt = RUN;
            end
            RUN: begin
                cpu_rst  = 1'b0;
                ld_ready = 1'b0;
                if (reload) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    assign in_io      = (address >= IO_BASE);
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign fifo_head  = fifo_mem[rd_ptr[AW-1:0]];

    // A reload in LOAD discards a coincident load word; in RUN the CPU write still lands.
    assign ld_fire   = (state == LOAD) && ld_valid && !reload;
    assign cpu_wr    = (state == RUN) && ce && we;
    assign ram_we    = ld_fire || (cpu_wr && !in_io);
    assign ram_addr  = ld_fire ? ptr : address;
    assign ram_wdata = ld_fire ? ld_data : dataW;

    assign push_req = cpu_wr && in_io;
    assign pop      = out_valid && out_ready;
    assign push     = push_req && (!fifo_full || pop);
    assign drop     = push_req && fifo_full && !pop;
    assign flush    = (state == RUN) && reload;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= 8'd0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            if (reload)       ptr <= 8'd0;
            else if (ld_fire) ptr <= ptr + 8'd1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                ovf    <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + FIFO_ONE;
                if (pop)  rd_ptr <= rd_ptr + FIFO_ONE;
                if (drop) ovf    <= 1'b1;
            end
        end
    end

    // RAM and FIFO storage are deliberately unreset; contents survive rst_n and reload.
    always_ff @(posedge ck) begin
        if (rst_n && ram_we) ram[ram_addr] <= ram_wdata;
    end

    always_ff @(posedge ck) begin
        if (rst_n && push) fifo_mem[wr_ptr[AW-1:0]] <= {address[3:0], dataW};
    end

    always_comb begin
        dataR = 16'h0000;
        if (!in_io)                dataR = ram[address];
        else if (address == 8'hFF) dataR = {14'b0, ovf, fifo_full};
    end

    assign out_valid = !fifo_empty;
    assign out_addr  = out_valid ? fifo_head[19:16] : 4'h0;
    assign out_data  = out_valid ? fifo_head[15:0]  : 16'h0000;
endmodule

// File: tb/tb_nano_mem_responder.sv
// Randomized scoreboard bench for nano_mem_responder: a behavioural RAM/FIFO model
// predicts responses, and a negedge monitor checks every FIFO pop against the queue.
module tb_nano_mem_responder;
    localparam int DEPTH = 4;

    logic        ck = 1'b0;
    logic        rst_n;
    logic [7:0]  address;
    logic [15:0] dataR, dataW, ld_data, out_data;
    logic        ce, we, cpu_rst, reload, ld_valid, ld_ready, ld_last;
    logic        out_valid, out_ready, ovf;
    logic [3:0]  out_addr;

    always #5 ck = ~ck;

    nano_mem_responder #(.IO_BASE(8'hF0), .FIFO_DEPTH(DEPTH)) dut (
        .ck(ck), .rst_n(rst_n), .address(address), .dataR(dataR), .dataW(dataW),
        .ce(ce), .we(we), .cpu_rst(cpu_rst), .reload(reload), .ld_valid(ld_valid),
        .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data), .ovf(ovf)
    );

    int tests = 0;
    int fails = 0;

    // behavioural model
    logic [15:0] m_ram [256];
    bit          m_run;
    logic [7:0]  m_ptr;
    int          m_cnt;
    bit          m_ovf;
    logic [19:0] exp_q [$];
    logic [19:0] last_pop;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_run = 0; m_ptr = 8'd0; m_cnt = 0; m_ovf = 0;
        exp_q.delete();
    endfunction

    function automatic void model_step();
        bit pop_m;
        pop_m = (m_cnt > 0) && out_ready;
        if (!m_run) begin
            if (reload) m_ptr = 8'd0;
            else if (ld_valid) begin
                m_ram[m_ptr] = ld_data;
                m_ptr = m_ptr + 8'd1;
                if (ld_last) m_run = 1;
            end
        end else begin
            if (ce && we && address < 8'hF0) m_ram[address] = dataW;
            if (ce && we && address >= 8'hF0) begin
                if (m_cnt < DEPTH || pop_m) begin
                    exp_q.push_back({address[3:0], dataW});
                    m_cnt++;
                end else m_ovf = 1;
            end
            if (pop_m) m_cnt--;
            if (reload) begin
                m_run = 0; m_ptr = 8'd0; m_cnt = 0; m_ovf = 0;
                exp_q.delete();
            end
        end
    endfunction

    always @(posedge ck) if (rst_n === 1'b1) model_step();

    // monitor: compare every presented/popped FIFO head with the scoreboard
    always @(negedge ck) begin
        if (rst_n === 1'b1) begin
            chk("out_valid", out_valid, m_cnt != 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL pop_unexpected: got %h expected none", {out_addr, out_data});
                end else begin
                    logic [19:0] e;
                    e = exp_q.pop_front();
                    chk("pop_entry", {out_addr, out_data}, e);
                    last_pop = {out_addr, out_data};
                end
            end
        end
    end

    task automatic step();
        @(posedge ck); #1;
    endtask

    task automatic load_word(input logic [15:0] d, input bit last);
        ld_valid = 1; ld_data = d; ld_last = last;
        step();
        ld_valid = 0; ld_last = 0;
    endtask

    task automatic chk_rd(input string n, input logic [7:0] a);
        logic [15:0] e;
        address = a; #1;
        if (a < 8'hF0)      e = m_ram[a];
        else if (a == 8'hFF) e = {14'b0, m_ovf, (m_cnt == DEPTH)};
        else                e = 16'h0000;
        chk(n, dataR, e);
    endtask

    task automatic chk_lit(input string n, input logic [7:0] a, input logic [15:0] e);
        address = a; #1;
        chk(n, dataR, e);
    endtask

    task automatic io_write(input logic [7:0] a, input logic [15:0] d);
        address = a; dataW = d; ce = 1; we = 1;
        step();
        ce = 0; we = 0;
    endtask

    task automatic drain();
        out_ready = 1;
        for (int c = 0; c < 20 && out_valid; c++) step();
        chk("drained", out_valid, 0);
        chk("drained_q", exp_q.size(), 0);
    endtask

    task automatic chk_reset_outs(input string n);
        chk({n, "_cpu_rst"}, cpu_rst, 1);
        chk({n, "_ld_ready"}, ld_ready, 1);
        chk({n, "_out_valid"}, out_valid, 0);
        chk({n, "_ovf"}, ovf, 0);
        chk({n, "_out_addr"}, out_addr, 0);
        chk({n, "_out_data"}, out_data, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] w256, w257, wd;
        int          k;
        bit          v;
        address = 0; dataW = 0; ce = 0; we = 0; reload = 0;
        ld_valid = 0; ld_data = 0; ld_last = 0; out_ready = 0;
        last_pop = '0;
        model_reset();
        rst_n = 1; #2 rst_n = 0; #10;
        chk_reset_outs("reset");
        step(); rst_n = 1;

        // load and run
        load_word(16'h4000, 0);
        load_word(16'h4111, 0);
        chk("cpu_rst_loading", cpu_rst, 1);
        load_word(16'hF000, 1);
        chk("cpu_rst_run", cpu_rst, 0);
        chk("ld_ready_run", ld_ready, 0);
        chk_lit("ram0", 8'd0, 16'h4000);
        chk_lit("ram1", 8'd1, 16'h4111);
        chk_lit("ram2", 8'd2, 16'hF000);

        // backpressure and wrap
        reload = 1; step(); reload = 0;
        chk("reload_cpu_rst", cpu_rst, 1);
        k = 0; w256 = 0; w257 = 0;
        for (int c = 0; c < 3000 && k < 258; c++) begin
            v = 1'($urandom_range(0, 1));
            wd = 16'($urandom);
            ld_valid = v; ld_data = wd; ld_last = (k == 257);
            if (v && k == 257) chk("cpu_rst_before_last", cpu_rst, 1);
            if (v && ld_ready) begin
                if (k == 256) w256 = wd;
                if (k == 257) w257 = wd;
                k++;
            end
            step();
        end
        ld_valid = 0; ld_last = 0;
        chk("wrap_words", k, 258);
        chk("wrap_cpu_rst", cpu_rst, 0);
        chk_lit("wrap_ram0", 8'd0, w256);
        chk_lit("wrap_ram1", 8'd1, w257);
        for (int a = 2; a < 256; a++) begin
            chk_rd("ram_sweep", 8'(a));
            step();
        end

        // RAM write in RUN: new value only after the edge
        address = 8'h10; dataW = 16'h0005; ce = 1; we = 1; #1;
        chk("no_bypass", dataR, m_ram[8'h10]);
        step(); ce = 0; we = 0; #1;
        chk("ram_wr", dataR, 16'h0005);
        chk("ram_wr_fifo", out_valid, 0);

        // I/O capture with overflow
        out_ready = 0;
        for (int i = 1; i <= 5; i++) io_write(8'hF2, 16'(i));
        chk("ovf_set", ovf, 1);
        chk("io_valid", out_valid, 1);
        chk_lit("status_ff", 8'hFF, 16'h0003);
        chk_lit("io_other", 8'hF3, 16'h0000);
        drain();
        chk("last_io", last_pop, {4'h2, 16'h0004});

        // push and pop in the same cycle while full
        out_ready = 0;
        for (int i = 0; i < 4; i++) io_write(8'(8'hF0 + $urandom_range(0, 15)), 16'(16'h0100 + i));
        out_ready = 1;
        io_write(8'hF5, 16'hAAAA);
        out_ready = 0;
        chk_lit("full_after_pushpop", 8'hFF, 16'h0003);
        drain();
        chk("aaaa_last", last_pop, {4'h5, 16'hAAAA});

        // randomized RUN traffic
        for (int c = 0; c < 300; c++) begin
            ce = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            dataW = 16'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            chk_rd("rand_rd", 8'($urandom));
            step();
        end
        ce = 0; we = 0;
        drain();

        // reload during RUN with pending entries and a coincident RAM write
        out_ready = 0;
        for (int i = 0; i < 5; i++) io_write(8'hF1, 16'(i));
        address = 8'h20; dataW = 16'h1234; ce = 1; we = 1; reload = 1;
        step();
        ce = 0; we = 0; reload = 0;
        chk("rl_cpu_rst", cpu_rst, 1);
        chk("rl_ld_ready", ld_ready, 1);
        chk("rl_empty", out_valid, 0);
        chk("rl_ovf", ovf, 0);
        load_word(16'hBEEF, 0);
        reload = 1; ld_valid = 1; ld_data = 16'h2222;
        step();
        reload = 0; ld_valid = 0;
        load_word(16'h3333, 1);
        chk_lit("rl_ram0", 8'd0, 16'h3333);
        chk_rd("rl_ram1", 8'd1);
        chk_lit("rl_ram20", 8'h20, 16'h1234);

        // async reset in RUN with pending entries and ovf set
        for (int i = 0; i < 5; i++) io_write(8'hF7, 16'(16'h0200 + i));
        #3 rst_n = 0; model_reset(); #1;
        chk_reset_outs("arst_run");
        step(); rst_n = 1;

        // async reset mid-load: ptr restarts at 0
        load_word(16'h5555, 0);
        load_word(16'h6666, 0);
        #3 rst_n = 0; model_reset(); #1;
        chk_reset_outs("arst_load");
        step(); rst_n = 1;
        load_word(16'h7777, 1);
        chk_lit("arst_ram0", 8'd0, 16'h7777);
        chk_lit("arst_ram1", 8'd1, 16'h6666);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
